// File: rtl/bp_table_if.sv
// Update and table-write bundle between EX, the branch-predictor tables and bp_table_ctrl.
// master is the controller side; slave is the pipeline/table side.
interface bp_table_if #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned PHT_W = 2
);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic             clr_req;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic [PHT_W-1:0] upd_state;
  logic             upd_ready;
  logic             bp_ready;
  logic             pht_we;
  logic             btb_we;
  logic [IDX_W-1:0] tbl_widx;
  logic [PHT_W-1:0] pht_wstate;
  logic             btb_wvalid;
  logic [TAG_W-1:0] btb_wtag;
  logic [PC_W-1:0]  btb_wtarget;

  modport master (
    input  clr_req, upd_valid, upd_pc, upd_taken, upd_target, upd_state,
    output upd_ready, bp_ready, pht_we, btb_we, tbl_widx, pht_wstate,
           btb_wvalid, btb_wtag, btb_wtarget
  );

  modport slave (
    output clr_req, upd_valid, upd_pc, upd_taken, upd_target, upd_state,
    input  upd_ready, bp_ready, pht_we, btb_we, tbl_widx, pht_wstate,
           btb_wvalid, btb_wtag, btb_wtarget
  );
endinterface

// File: rtl/bp_table_ctrl.sv
// Write-port controller for the PHT/BTB: initialisation sweep after reset/clear,
// then in-order retirement of queued resolved-branch updates, one per cycle.
module bp_table_ctrl #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned PHT_W  = 2,
  parameter int unsigned QDEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  bp_table_if.master bus
);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;
  localparam int unsigned NENT  = 1 << IDX_W;
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {INIT, RUN} state_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic [PC_W-1:0]  target;
    logic [PHT_W-1:0] state;
  } upd_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  upd_t             q_mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  upd_t             head;
  logic             push, pop, last_sweep;

  logic             n_pht_we, n_btb_we, n_btb_wvalid;
  logic [IDX_W-1:0] n_widx;
  logic [PHT_W-1:0] n_pht_wstate;
  logic [TAG_W-1:0] n_btb_wtag;
  logic [PC_W-1:0]  n_btb_wtarget;
  logic             unused_pc_lsb;

  function automatic logic [PHT_W-1:0] pht_next(input logic [PHT_W-1:0] s, input logic t);
    if (t) return (&s) ? s : s + PHT_W'(1);
    else   return (s == '0) ? s : s - PHT_W'(1);
  endfunction

  // Back-pressure comes from the registered count; a clear drops whatever is offered.
  assign bus.upd_ready = !bus.clr_req && (count != CNT_W'(QDEPTH));
  assign push          = bus.upd_valid && bus.upd_ready;
  assign last_sweep    = (state == INIT) && (cnt == IDX_W'(NENT - 1));
  assign pop           = !bus.clr_req && (count != '0) && ((state == RUN) || last_sweep);
  assign head          = q_mem[rd_ptr];
  assign unused_pc_lsb = ^{bus.upd_pc[1:0], head.pc[1:0]};

  // Next write-port contents; outputs below are the registered copy.
  always_comb begin
    n_pht_we      = 1'b0;
    n_btb_we      = 1'b0;
    n_btb_wvalid  = 1'b0;
    n_widx        = '0;
    n_pht_wstate  = '0;
    n_btb_wtag    = '0;
    n_btb_wtarget = '0;
    if (reset || bus.clr_req || ((state == INIT) && !last_sweep)) begin
      n_pht_we     = 1'b1;
      n_btb_we     = 1'b1;
      n_pht_wstate = PHT_W'(1);
      n_widx       = (reset || bus.clr_req) ? '0 : cnt + IDX_W'(1);
    end else if (pop) begin
      n_pht_we     = 1'b1;
      n_widx       = head.pc[IDX_W+1:2];
      n_pht_wstate = pht_next(head.state, head.taken);
      if (head.taken) begin
        n_btb_we      = 1'b1;
        n_btb_wvalid  = 1'b1;
        n_btb_wtag    = head.pc[PC_W-1:IDX_W+2];
        n_btb_wtarget = head.target;
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset)
      q_mem[wr_ptr] <= '{pc: bus.upd_pc, taken: bus.upd_taken,
                         target: bus.upd_target, state: bus.upd_state};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      cnt          <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus.bp_ready <= 1'b0;
    end else if (bus.clr_req) begin
      state        <= INIT;
      cnt          <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus.bp_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case (state)
        INIT: begin
          if (last_sweep) begin
            state        <= RUN;
            bus.bp_ready <= 1'b1;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    bus.pht_we      <= n_pht_we;
    bus.btb_we      <= n_btb_we;
    bus.tbl_widx    <= n_widx;
    bus.pht_wstate  <= n_pht_wstate;
    bus.btb_wvalid  <= n_btb_wvalid;
    bus.btb_wtag    <= n_btb_wtag;
    bus.btb_wtarget <= n_btb_wtarget;
  end
endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl: directed steps plus random traffic, every cycle
// checked against a queue-based model of the sweep and update retirement.
module tb_bp_table_ctrl;
  localparam int IDX_W  = 4;
  localparam int PC_W   = 32;
  localparam int PHT_W  = 2;
  localparam int QDEPTH = 4;
  localparam int NENT   = 1 << IDX_W;
  localparam int PMAX   = (1 << PHT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_table_if #(.IDX_W(IDX_W), .PC_W(PC_W), .PHT_W(PHT_W)) bus ();
  bp_table_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W), .PHT_W(PHT_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
    int          st;
  } upd_s;

  upd_s mq[$];
  int   sweep_pos;
  int   total = 0;
  int   bad   = 0;
  bit   e_we, e_bwe, e_bval, e_rdy;
  logic [63:0] e_idx, e_wst, e_tag, e_tgt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sweep(input int p);
    e_we = 1; e_bwe = 1; e_bval = 0; e_rdy = 0;
    e_idx = 64'(p); e_wst = 64'd1; e_tag = 0; e_tgt = 0;
  endtask

  // Model of one clock edge: clear, pop of an eligible entry, sweep progress, push.
  task automatic model_edge(input bit clr, input bit valid, input upd_s u);
    bit   acc, popped;
    upd_s h;
    int   ns;
    acc = valid && !clr && (mq.size() < QDEPTH);
    popped = 0;
    if (clr) begin
      sweep_pos = 0;
      mq.delete();
    end else begin
      if ((sweep_pos < 0 || sweep_pos == NENT - 1) && mq.size() > 0) begin
        h = mq.pop_front();
        popped = 1;
      end
      if (sweep_pos >= 0) sweep_pos = (sweep_pos == NENT - 1) ? -1 : sweep_pos + 1;
      if (acc) mq.push_back(u);
    end
    if (sweep_pos >= 0) expect_sweep(sweep_pos);
    else begin
      e_rdy = 1; e_we = 0; e_bwe = 0; e_bval = 0;
      e_idx = 0; e_wst = 0; e_tag = 0; e_tgt = 0;
      if (popped) begin
        ns     = h.taken ? ((h.st + 1 > PMAX) ? PMAX : h.st + 1)
                         : ((h.st - 1 < 0) ? 0 : h.st - 1);
        e_we   = 1;
        e_idx  = 64'((h.pc / 4) % NENT);
        e_wst  = 64'(ns);
        e_bwe  = h.taken;
        e_bval = h.taken;
        e_tag  = h.taken ? 64'(h.pc >> (IDX_W + 2)) : 64'd0;
        e_tgt  = h.taken ? 64'(h.tgt) : 64'd0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("bp_ready", 64'(bus.bp_ready), 64'(e_rdy));
    chk("pht_we", 64'(bus.pht_we), 64'(e_we));
    chk("btb_we", 64'(bus.btb_we), 64'(e_bwe));
    if (e_we) begin
      chk("tbl_widx", 64'(bus.tbl_widx), e_idx);
      chk("pht_wstate", 64'(bus.pht_wstate), e_wst);
    end
    if (e_bwe) begin
      chk("btb_wvalid", 64'(bus.btb_wvalid), 64'(e_bval));
      chk("btb_wtag", 64'(bus.btb_wtag), e_tag);
      chk("btb_wtarget", 64'(bus.btb_wtarget), e_tgt);
    end
  endtask

  // One cycle: drive at negedge, check ready, clock, then check registered outputs.
  task automatic step(input bit clr, input bit valid, input logic [31:0] pc,
                      input bit tk, input logic [31:0] tgt, input int st);
    upd_s u;
    bus.clr_req    = clr;
    bus.upd_valid  = valid;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    bus.upd_state  = PHT_W'(st);
    #1;
    chk("upd_ready", 64'(bus.upd_ready), 64'(!clr && (mq.size() < QDEPTH)));
    u = '{pc: pc, taken: tk, tgt: tgt, st: st};
    @(posedge clk);
    model_edge(clr, valid, u);
    @(negedge clk);
    bus.clr_req   = 1'b0;
    bus.upd_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    sweep_pos = 0;
    mq.delete();
    expect_sweep(0);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.clr_req = 0; bus.upd_valid = 0; bus.upd_pc = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.upd_state = 0;

    // Sweep after reset: 16 index writes, ready on the 17th cycle.
    do_reset();
    chk("t1_idx0", 64'(bus.tbl_widx), 64'd0);
    idle(15);
    chk("t1_idx15", 64'(bus.tbl_widx), 64'd15);
    chk("t1_not_ready", 64'(bus.bp_ready), 64'd0);
    idle(1);
    chk("t1_ready17", 64'(bus.bp_ready), 64'd1);

    // Single taken update, one-cycle latency.
    step(0, 1, 32'h1c000010, 1, 32'h1c000100, 1);
    chk("t2_no_write_yet", 64'(bus.pht_we), 64'd0);
    idle(1);
    chk("t2_idx", 64'(bus.tbl_widx), 64'd4);
    chk("t2_wstate", 64'(bus.pht_wstate), 64'd2);
    chk("t2_tag", 64'(bus.btb_wtag), 64'h1c000010 >> 6);

    // Saturation at both ends.
    step(0, 1, 32'h00000abc, 1, 32'h00004000, 3);
    step(0, 1, 32'h00000124, 0, 32'h0, 0);
    chk("t3_sat_hi", 64'(bus.pht_wstate), 64'd3);
    idle(1);
    chk("t3_sat_lo", 64'(bus.pht_wstate), 64'd0);
    chk("t3_nt_btb", 64'(bus.btb_we), 64'd0);
    idle(2);

    // Five pushes during INIT: fourth fills the queue, fifth dropped, drain after sweep.
    do_reset();
    for (int i = 0; i < 5; i++)
      step(0, 1, 32'h40000000 + 32'(i * 4), i[0], 32'h80000000 + 32'(i), i % 4);
    chk("t4_full", 64'(bus.upd_ready), 64'd0);
    idle(14);

    // Clear with three queued and an update offered: nothing queued ever retires.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 32'h00000100 + 32'(i * 4), 1, 32'h7000, 2);
    step(1, 1, 32'h00000200, 1, 32'h7100, 1);
    idle(24);

    // Clear mid-sweep restarts from index 0; RUN reached NENT cycles later.
    do_reset();
    idle(9);
    chk("t6_at9", 64'(bus.tbl_widx), 64'd9);
    step(1, 0, 32'h0, 0, 32'h0, 0);
    chk("t6_restart", 64'(bus.tbl_widx), 64'd0);
    n = 0;
    while (!bus.bp_ready && n < 40) begin
      idle(1);
      n++;
    end
    chk("t6_sweep_len", 64'(n), 64'(NENT));

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, PMAX));
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
